// File: rtl/sys_frame_timing_gen.sv
// sys_frame_timing_gen
//   Frame timing generator. A free-running frame counter produces the 10 ms and
//   5 ms head pulses, the half-frame indicator, a 10-bit frame number and
//   per-channel offset ticks. The counter is aligned to an external 10 ms
//   reference through a HUNT/CHECK/LOCK/HOLD tracker that counts misaligned and
//   missing reference heads.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   i_ref_frame_10ms  external 10 ms head (asynchronous level)
//   i_cfg_gap         counter load value applied on reference alignment
//   i_ch_offset       per-channel tick position, channel k at [k*CNT_W +: CNT_W]
//   i_ch_en           per-channel tick enable
//   i_clr_stat        clear the error/miss statistics
//   o_frame_10ms      10 ms head pulse, PULSE_W cycles
//   o_frame_5ms       5 ms head pulse, PULSE_W cycles
//   o_frame_kind      1 = first half-frame, 0 = second half-frame
//   o_sfn             frame number (mod 1024)
//   o_ch_tick         one-cycle channel ticks
//   o_state           tracker state (HUNT=0, CHECK=1, LOCK=2, HOLD=3)
//   o_ref_err_cnt     saturating misaligned-head count
//   o_ref_miss_cnt    saturating missing-head count
module sys_frame_timing_gen #(
    parameter int FRAME_TICKS = 1228800,
    parameter int CNT_W       = 23,
    parameter int N_CH        = 4,
    parameter int LOCK_CNT    = 3,
    parameter int MISS_MAX    = 2,
    parameter int PULSE_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_ref_frame_10ms,
    input  logic [CNT_W-1:0]      i_cfg_gap,
    input  logic [N_CH*CNT_W-1:0] i_ch_offset,
    input  logic [N_CH-1:0]       i_ch_en,
    input  logic                  i_clr_stat,
    output logic                  o_frame_10ms,
    output logic                  o_frame_5ms,
    output logic                  o_frame_kind,
    output logic [9:0]            o_sfn,
    output logic [N_CH-1:0]       o_ch_tick,
    output logic [1:0]            o_state,
    output logic [7:0]            o_ref_err_cnt,
    output logic [7:0]            o_ref_miss_cnt
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] LP_HALF = CNT_W'(FRAME_TICKS / 2 - 1);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
    localparam int               PW_W    = $clog2(PULSE_W + 1);
    localparam int               GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam int               MR_W    = $clog2(MISS_MAX + 1);
    localparam logic [PW_W-1:0]  LP_PW   = PW_W'(PULSE_W);
    localparam logic [PW_W-1:0]  PW_ONE  = PW_W'(1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOCK  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic               r_ref_p;
    logic [CNT_W-1:0]   r_cnt;
    logic [GOOD_W-1:0]  r_good;
    logic [GOOD_W-1:0]  w_good_nxt;
    logic [MR_W-1:0]    r_miss_run;
    logic [MR_W-1:0]    w_mr_nxt;
    logic [PW_W-1:0]    r_p10_rem;
    logic [PW_W-1:0]    r_p5_rem;
    logic               r_kind;
    logic [9:0]         r_sfn;
    logic [N_CH-1:0]    r_ch_tick;
    logic [7:0]         r_err;
    logic [7:0]         r_miss;

    logic [CNT_W-1:0]   w_exp;
    logic               w_at_exp;
    logic               w_aligned;
    logic               w_misal;
    logic               w_miss;
    logic               w_head;
    logic               w_half;
    logic               w_reload;
    logic               w_err_inc;
    logic               w_miss_inc;
    logic               w_sfn_clr;

    // Reference position: the head must land on the count just before the
    // load value, so a reload is seamless when the reference is aligned.
    assign w_exp     = (i_cfg_gap == '0) ? LP_LAST : (i_cfg_gap - LP_ONE);
    assign w_at_exp  = (r_cnt == w_exp);
    assign w_aligned = r_ref_p & w_at_exp;
    assign w_misal   = r_ref_p & ~w_at_exp;
    assign w_miss    = ~r_ref_p & w_at_exp;
    assign w_head    = (r_cnt == LP_LAST);
    assign w_half    = (r_cnt == LP_HALF);

    // Two-flop synchroniser, then a registered rising-edge strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_ref_p <= 1'b0;
        end else begin
            r_sync1 <= i_ref_frame_10ms;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_ref_p <= r_sync2 & ~r_sync3;
        end
    end

    // Tracker: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_HUNT;
            r_good     <= '0;
            r_miss_run <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good     <= w_good_nxt;
            r_miss_run <= w_mr_nxt;
        end
    end

    // Tracker: next state and actions
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_mr_nxt    = r_miss_run;
        w_reload    = 1'b0;
        w_err_inc   = 1'b0;
        w_miss_inc  = 1'b0;
        w_sfn_clr   = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (r_ref_p) begin
                    w_reload    = 1'b1;
                    w_good_nxt  = GOOD_W'(1);
                    w_mr_nxt    = '0;
                    w_sfn_clr   = 1'b1;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_aligned) begin
                    w_good_nxt = r_good + GOOD_W'(1);
                    if (r_good >= GOOD_W'(LOCK_CNT - 1)) begin
                        w_mr_nxt    = '0;
                        w_state_nxt = ST_LOCK;
                    end
                end else if (w_misal) begin
                    w_reload   = 1'b1;
                    w_good_nxt = GOOD_W'(1);
                    w_err_inc  = 1'b1;
                end else if (w_miss) begin
                    w_good_nxt  = '0;
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_LOCK: begin
                if (w_aligned) begin
                    w_mr_nxt = '0;
                end else if (w_misal) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (w_miss) begin
                    w_miss_inc = 1'b1;
                    w_mr_nxt   = r_miss_run + MR_W'(1);
                    if (r_miss_run >= MR_W'(MISS_MAX - 1)) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_aligned) begin
                    w_mr_nxt    = '0;
                    w_state_nxt = ST_LOCK;
                end else if (w_misal) begin
                    w_reload    = 1'b1;
                    w_good_nxt  = GOOD_W'(1);
                    w_mr_nxt    = '0;
                    w_err_inc   = 1'b1;
                    w_state_nxt = ST_CHECK;
                end else if (w_miss) begin
                    w_miss_inc = 1'b1;
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    // Tracker: outputs
    always_comb begin
        o_state        = r_state;
        o_frame_10ms   = (r_p10_rem != '0);
        o_frame_5ms    = (r_p5_rem != '0);
        o_frame_kind   = r_kind;
        o_sfn          = r_sfn;
        o_ch_tick      = r_ch_tick;
        o_ref_err_cnt  = r_err;
        o_ref_miss_cnt = r_miss;
    end

    // Frame counter and head decodes. Decodes use the pre-reload count, so a
    // reload landing on the last tick still emits that head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_p10_rem <= '0;
            r_p5_rem  <= '0;
            r_kind    <= 1'b0;
            r_sfn     <= '0;
        end else begin
            if (w_reload) begin
                r_cnt <= i_cfg_gap;
            end else if (w_head) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + LP_ONE;
            end

            if (w_head) begin
                r_p10_rem <= LP_PW;
            end else if (r_p10_rem != '0) begin
                r_p10_rem <= r_p10_rem - PW_ONE;
            end

            if (w_head || w_half) begin
                r_p5_rem <= LP_PW;
            end else if (r_p5_rem != '0) begin
                r_p5_rem <= r_p5_rem - PW_ONE;
            end

            if (w_head) begin
                r_kind <= 1'b1;
            end else if (w_half) begin
                r_kind <= 1'b0;
            end

            if (w_sfn_clr) begin
                r_sfn <= '0;
            end else if (w_head) begin
                r_sfn <= r_sfn + 10'd1;
            end
        end
    end

    // Channel ticks: offsets beyond the frame never match the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_tick <= '0;
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                r_ch_tick[k] <= i_ch_en[k] && (r_cnt == i_ch_offset[k*CNT_W +: CNT_W]);
            end
        end
    end

    // Statistics: clear takes priority over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err  <= '0;
            r_miss <= '0;
        end else if (i_clr_stat) begin
            r_err  <= '0;
            r_miss <= '0;
        end else begin
            if (w_err_inc && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
            if (w_miss_inc && (r_miss != 8'hFF)) begin
                r_miss <= r_miss + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sys_frame_timing_gen.sv
module tb_sys_frame_timing_gen;

    localparam int FT    = 100;
    localparam int CW    = 8;
    localparam int NCH   = 4;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic            clk;
    logic            rst;
    logic            i_ref_frame_10ms;
    logic [CW-1:0]   i_cfg_gap;
    logic [NCH*CW-1:0] i_ch_offset;
    logic [NCH-1:0]  i_ch_en;
    logic            i_clr_stat;
    logic            o_frame_10ms;
    logic            o_frame_5ms;
    logic            o_frame_kind;
    logic [9:0]      o_sfn;
    logic [NCH-1:0]  o_ch_tick;
    logic [1:0]      o_state;
    logic [7:0]      o_ref_err_cnt;
    logic [7:0]      o_ref_miss_cnt;

    int vec_cnt = 0;
    int mis_cnt = 0;
    int cyc = 0;
    logic prev10 = 1'b0;
    logic prev5  = 1'b0;

    ev_t q10[$];
    int  q5[$];
    int  qc0[$];
    int  qc1[$];

    sys_frame_timing_gen #(
        .FRAME_TICKS (FT),
        .CNT_W       (CW),
        .N_CH        (NCH),
        .LOCK_CNT    (3),
        .MISS_MAX    (2),
        .PULSE_W     (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_ref_frame_10ms (i_ref_frame_10ms),
        .i_cfg_gap        (i_cfg_gap),
        .i_ch_offset      (i_ch_offset),
        .i_ch_en          (i_ch_en),
        .i_clr_stat       (i_clr_stat),
        .o_frame_10ms     (o_frame_10ms),
        .o_frame_5ms      (o_frame_5ms),
        .o_frame_kind     (o_frame_kind),
        .o_sfn            (o_sfn),
        .o_ch_tick        (o_ch_tick),
        .o_state          (o_state),
        .o_ref_err_cnt    (o_ref_err_cnt),
        .o_ref_miss_cnt   (o_ref_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges since reset release
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vec_cnt++;
        assert (obs === exp) else begin
            mis_cnt++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Reference edge raised so the synchronised strobe is evaluated at edge d.
    task automatic ref_at(input int d);
        wait_cyc(d - 4);
        i_ref_frame_10ms = 1'b1;
        wait_cyc(d - 2);
        i_ref_frame_10ms = 1'b0;
    endtask

    // Scoreboard monitor: pops expected events when the DUT emits pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_frame_10ms && !prev10) begin
                if (q10.size() == 0) begin
                    chk("f10_unexpected", cyc, -1);
                end else begin
                    ev_t e;
                    e = q10.pop_front();
                    chk("f10_rise_cycle", cyc, e.cyc);
                    chk("sfn_at_rise", int'(o_sfn), e.val);
                end
            end
            if (o_frame_5ms && !prev5) begin
                if (q5.size() == 0) chk("f5_unexpected", cyc, -1);
                else                chk("f5_rise_cycle", cyc, q5.pop_front());
            end
            if (o_ch_tick[0]) begin
                if (qc0.size() == 0) chk("ch0_unexpected", cyc, -1);
                else                 chk("ch0_tick_cycle", cyc, qc0.pop_front());
            end
            if (o_ch_tick[1]) begin
                if (qc1.size() == 0) chk("ch1_unexpected", cyc, -1);
                else                 chk("ch1_tick_cycle", cyc, qc1.pop_front());
            end
            if (o_ch_tick[2]) chk("ch2_unexpected", cyc, -1);
            if (o_ch_tick[3]) chk("ch3_unexpected", cyc, -1);
        end
        prev10 = o_frame_10ms;
        prev5  = o_frame_5ms;
    end

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        i_ref_frame_10ms = 1'b0;
        i_cfg_gap        = 8'd10;
        i_ch_offset      = {8'd5, 8'd150, 8'd99, 8'd0};
        i_ch_en          = 4'b0111;
        i_clr_stat       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_state", int'(o_state), 0);
        chk("rst_f10", int'(o_frame_10ms), 0);
        chk("rst_f5", int'(o_frame_5ms), 0);
        chk("rst_kind", int'(o_frame_kind), 0);
        chk("rst_sfn", int'(o_sfn), 0);
        chk("rst_ticks", int'(o_ch_tick), 0);
        chk("rst_err", int'(o_ref_err_cnt), 0);
        chk("rst_miss", int'(o_ref_miss_cnt), 0);

        // Free run without reference
        q10.push_back('{100, 1});
        q10.push_back('{200, 2});
        for (int c = 50; c <= 250; c += 50) q5.push_back(c);
        qc0.push_back(1); qc0.push_back(101); qc0.push_back(201);
        qc1.push_back(100); qc1.push_back(200);
        rst = 1'b0;

        wait_cyc(230);
        chk("free_state", int'(o_state), 0);

        // Acquisition: first head at 260 reloads cnt to 10; frame timing shifts
        for (int c = 350; c <= 850; c += 100) q10.push_back('{c, (c - 250) / 100});
        for (int c = 300; c <= 900; c += 50) q5.push_back(c);
        for (int c = 351; c <= 851; c += 100) qc0.push_back(c);
        for (int c = 350; c <= 850; c += 100) qc1.push_back(c);

        ref_at(260);
        wait_cyc(261);
        chk("hunt_to_check", int'(o_state), 1);
        wait_cyc(320);
        chk("kind_second_half", int'(o_frame_kind), 0);
        wait_cyc(355);
        chk("kind_first_half", int'(o_frame_kind), 1);
        ref_at(360);
        wait_cyc(361);
        chk("check_good2", int'(o_state), 1);
        ref_at(460);
        wait_cyc(461);
        chk("check_to_lock", int'(o_state), 2);
        chk("lock_err_zero", int'(o_ref_err_cnt), 0);

        // Early head in LOCK, then an aligned one
        ref_at(553);
        wait_cyc(554);
        chk("early_to_hold", int'(o_state), 3);
        chk("early_err", int'(o_ref_err_cnt), 1);
        ref_at(560);
        wait_cyc(561);
        chk("hold_to_lock", int'(o_state), 2);
        chk("no_miss_yet", int'(o_ref_miss_cnt), 0);

        // Reference removed
        wait_cyc(661);
        chk("miss1_cnt", int'(o_ref_miss_cnt), 1);
        chk("miss1_state", int'(o_state), 2);
        wait_cyc(761);
        chk("miss2_cnt", int'(o_ref_miss_cnt), 2);
        chk("miss2_state", int'(o_state), 3);
        wait_cyc(861);
        chk("miss3_cnt", int'(o_ref_miss_cnt), 3);
        chk("miss3_state", int'(o_state), 3);

        // 300 misaligned heads every 8 cycles; clear coincides with head 260
        for (int k = 1; k <= 300; k++) begin
            int d;
            d = 900 + 8 * (k - 1);
            ref_at(d);
            if (k == 260) begin
                wait_cyc(d - 1);
                i_clr_stat = 1'b1;
                wait_cyc(d);
                i_clr_stat = 1'b0;
            end
            if (k == 254 || k == 259 || k == 260 || k == 300) begin
                wait_cyc(d + 1);
                chk("err_cnt", int'(o_ref_err_cnt), (k == 260) ? 0 : (k == 300) ? 40 : 255);
                if (k == 260) chk("clr_miss", int'(o_ref_miss_cnt), 0);
            end
        end

        wait_cyc(3300);
        chk("final_state", int'(o_state), 1);
        chk("q10_left", q10.size(), 0);
        chk("q5_left", q5.size(), 0);
        chk("qc0_left", qc0.size(), 0);
        chk("qc1_left", qc1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
